// File: rtl/vc_router_param_pkg.sv
// Shared types and helpers for the parametrised VC router.
// Holds the arbitration-mode encoding and the id-width helper used for field slicing.
// Imported by the router top and its FIFO sub-module.
package vc_router_param_pkg;

  // Arbitration modes selectable through the ARB_MODE parameter.
  typedef enum logic {
    ARB_STRICT = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_e;

  // Width of an index field that names one of n items (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_router_param_fifo.sv
// Generic synchronous FIFO with full/empty/almost flags and sticky overflow/underflow errors.
// Latency: a pushed word is visible at dout the cycle after the push edge.
// Backpressure: push into a full FIFO is dropped unless a pop frees the slot in the same edge.
module fifo_param
  import vc_router_param_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign dout         = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array: no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err_overflow  <= err_overflow  | (push && !do_push);
      err_underflow <= err_underflow | (pop && empty);
    end
  end

endmodule

// File: rtl/vc_router_param.sv
// Routes words from NUM_VC input VC FIFOs to NUM_DEST destination FIFOs via one arbitrated transfer per cycle.
// Latency: 3 cycles from wr_enable to earliest valid_d (push, transfer, registered pop).
// Backpressure: a VC head stalls while its destination FIFO is almost full; VC overflow drops the word.
module vc_router_param
  import vc_router_param_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int NUM_VC    = 2,
  parameter int NUM_DEST  = 2,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  parameter int ARB_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       wr_enable,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_DEST-1:0]        dest_pop,
  output logic [NUM_DEST*DATA_W-1:0] data_out_d,
  output logic [NUM_DEST-1:0]        valid_d,
  output logic [NUM_VC-1:0]          vc_full,
  output logic [NUM_VC-1:0]          vc_empty,
  output logic [NUM_VC-1:0]          vc_almost_full,
  output logic [NUM_DEST-1:0]        dest_empty,
  output logic [NUM_VC-1:0]          error_vc,
  output logic [NUM_DEST-1:0]        error_d
);

  localparam int DEST_W = idx_w(NUM_DEST);
  localparam int VC_W   = idx_w(NUM_VC);

  // Word layout: destination id in the top DEST_W bits, VC id directly below it.
  logic [VC_W-1:0]                  in_vc;
  logic [NUM_VC-1:0][DATA_W-1:0]    vc_head;
  logic [NUM_VC-1:0]                vc_push;
  logic [NUM_VC-1:0]                vc_pop;
  logic [NUM_VC-1:0]                vc_elig;
  logic [NUM_VC-1:0]                unused_vc_ae;
  logic [NUM_VC-1:0]                unused_vc_uf;
  logic [NUM_DEST-1:0][DATA_W-1:0]  dest_head;
  logic [NUM_DEST-1:0]              dest_push;
  logic [NUM_DEST-1:0]              dest_af;
  logic [NUM_DEST-1:0]              unused_dest_full;
  logic [NUM_DEST-1:0]              unused_dest_ae;
  logic [NUM_DEST-1:0]              unused_dest_of;
  logic [VC_W-1:0]                  rr_ptr;
  logic [VC_W-1:0]                  arb_start;
  logic [VC_W-1:0]                  arb_cand;
  logic [VC_W-1:0]                  win;
  logic                             xfer_vld;
  logic [DATA_W-1:0]                xfer_dat;
  logic [DEST_W-1:0]                xfer_dest;

  assign in_vc     = data_in[DATA_W-1-DEST_W -: VC_W];
  assign xfer_dat  = vc_head[win];
  assign xfer_dest = xfer_dat[DATA_W-1 -: DEST_W];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign vc_push[v] = wr_enable && (in_vc == VC_W'(v));
    assign vc_pop[v]  = xfer_vld && (win == VC_W'(v));
    assign vc_elig[v] = !vc_empty[v] && !dest_af[vc_head[v][DATA_W-1 -: DEST_W]];

    fifo_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) u_vc_fifo (
      .clk(clk), .reset_L(reset_L),
      .push(vc_push[v]), .pop(vc_pop[v]), .din(data_in), .dout(vc_head[v]),
      .full(vc_full[v]), .empty(vc_empty[v]),
      .almost_full(vc_almost_full[v]), .almost_empty(unused_vc_ae[v]),
      .err_overflow(error_vc[v]), .err_underflow(unused_vc_uf[v])
    );
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
    assign dest_push[k] = xfer_vld && (xfer_dest == DEST_W'(k));

    fifo_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) u_dest_fifo (
      .clk(clk), .reset_L(reset_L),
      .push(dest_push[k]), .pop(dest_pop[k]), .din(xfer_dat), .dout(dest_head[k]),
      .full(unused_dest_full[k]), .empty(dest_empty[k]),
      .almost_full(dest_af[k]), .almost_empty(unused_dest_ae[k]),
      .err_overflow(unused_dest_of[k]), .err_underflow(error_d[k])
    );
  end

  // Pick the transfer winner: first eligible VC scanning up from rr_ptr (round-robin) or from 0 (strict).
  always_comb begin
    xfer_vld  = 1'b0;
    win       = '0;
    arb_cand  = '0;
    arb_start = (ARB_MODE == int'(ARB_RR)) ? rr_ptr : '0;
    for (int i = 0; i < NUM_VC; i++) begin
      arb_cand = arb_start + VC_W'(i);
      if (!xfer_vld && vc_elig[arb_cand]) begin
        xfer_vld = 1'b1;
        win      = arb_cand;
      end
    end
  end

  // Round-robin pointer advances past the winner only when a transfer happens.
  always_ff @(posedge clk) begin
    if (!reset_L)      rr_ptr <= '0;
    else if (xfer_vld) rr_ptr <= win + VC_W'(1);
  end

  // Registered destination outputs: capture the head on a successful pop, otherwise hold data.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out_d <= '0;
      valid_d    <= '0;
    end else begin
      for (int k = 0; k < NUM_DEST; k++) begin
        if (dest_pop[k] && !dest_empty[k]) begin
          data_out_d[k*DATA_W +: DATA_W] <= dest_head[k];
          valid_d[k]                     <= 1'b1;
        end else begin
          valid_d[k] <= 1'b0;
        end
      end
    end
  end

endmodule
